// File: rtl/request_unit_pkg.sv
// Shared types for the fetch/memory-request sequencer that feeds control_unit.
package request_unit_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    // {wen, ren}: a store wins when the decode illegally asks for both
    function automatic logic [1:0] mem_req(input logic ren, input logic wen);
        return {wen, ren & ~wen};
    endfunction

endpackage

// File: rtl/request_unit_if.sv
// Bundles the request_unit signals for blocks that prefer an interface hookup.
interface request_unit_if;
    import request_unit_pkg::*;

    logic  ihit;
    logic  dhit;
    logic  dRENi;
    logic  dWENi;
    logic  halt;
    word_t npc;
    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    logic  pc_wen;
    logic  halt_o;

    modport ru (
        input  ihit, dhit, dRENi, dWENi, halt, npc,
        output imemREN, imemaddr, dmemREN, dmemWEN, pc_wen, halt_o
    );

    modport tb (
        output ihit, dhit, dRENi, dWENi, halt, npc,
        input  imemREN, imemaddr, dmemREN, dmemWEN, pc_wen, halt_o
    );
endinterface

// File: rtl/request_unit.sv
// Owns the PC, issues instruction fetches, holds data requests until dhit,
// and counts retired instructions until a halt is decoded.
module request_unit
    import request_unit_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dRENi,
    input  logic             dWENi,
    input  logic             halt,
    input  logic [31:0]      npc,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_wen,
    output logic             halt_o,
    output logic [CNT_W-1:0] instr_cnt
);

    reqstate_t        state_q, state_d;
    word_t            pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dren_q, dren_d;
    logic             dwen_q, dwen_d;
    logic             pc_wen_c;
    logic [1:0]       req_c;

    assign req_c = mem_req(dRENi, dWENi);

    // Next-state, PC and counter update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        pc_wen_c = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (ihit) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (dRENi | dWENi) begin
                        state_d = DATA;
                        dwen_d  = req_c[1];
                        dren_d  = req_c[0];
                    end else begin
                        pc_wen_c = 1'b1;
                        pc_d     = npc;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_wen_c = 1'b1;
                    pc_d     = npc;
                    cnt_d    = cnt_q + CNT_W'(1);
                    dren_d   = 1'b0;
                    dwen_d   = 1'b0;
                    state_d  = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            cnt_q   <= '0;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
        end
    end

    // Retire pulse is suppressed while reset is applied so no PC write leaks out
    assign pc_wen    = pc_wen_c & ~RST;
    assign imemREN   = (state_q == FETCH);
    assign halt_o    = (state_q == HALTED);
    assign imemaddr  = pc_q;
    assign dmemREN   = dren_q;
    assign dmemWEN   = dwen_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: directed steps push hand-computed
// expectations, a negedge monitor pops and compares.
module tb_request_unit;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, dRENi, dWENi, halt;
    logic [31:0] npc;
    logic        imemREN, dmemREN, dmemWEN, pc_wen, halt_o;
    logic [31:0] imemaddr;
    logic [31:0] instr_cnt;

    logic        rst_b, ihit_b;
    logic        imemREN_b, dmemREN_b, dmemWEN_b, pc_wen_b, halt_o_b;
    logic [31:0] imemaddr_b;
    logic [3:0]  instr_cnt_b;

    typedef struct packed {
        logic [31:0] addr;
        logic        iren;
        logic        dren;
        logic        dwen;
        logic        pcw;
        logic        hlt;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        int   id;
        obs_t e;
    } exp_t;

    typedef struct {
        int       id;
        logic [3:0] cnt;
    } exp_b_t;

    exp_t   q_main[$];
    exp_b_t q_b[$];
    int     total = 0;
    int     bad   = 0;
    int     step_id = 0;

    request_unit #(.PC_INIT(32'h0000_0000), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dRENi(dRENi), .dWENi(dWENi), .halt(halt), .npc(npc),
        .imemREN(imemREN), .imemaddr(imemaddr), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .pc_wen(pc_wen), .halt_o(halt_o),
        .instr_cnt(instr_cnt)
    );

    request_unit #(.PC_INIT(32'h0000_0100), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(rst_b), .ihit(ihit_b), .dhit(1'b0),
        .dRENi(1'b0), .dWENi(1'b0), .halt(1'b0), .npc(32'h0000_0104),
        .imemREN(imemREN_b), .imemaddr(imemaddr_b), .dmemREN(dmemREN_b),
        .dmemWEN(dmemWEN_b), .pc_wen(pc_wen_b), .halt_o(halt_o_b),
        .instr_cnt(instr_cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: outputs settle mid-cycle, compare on the falling edge
    always @(negedge CLK) begin
        if (q_main.size() > 0) begin
            exp_t x;
            obs_t a;
            x = q_main.pop_front();
            a = '{addr: imemaddr, iren: imemREN, dren: dmemREN, dwen: dmemWEN,
                  pcw: pc_wen, hlt: halt_o, cnt: instr_cnt};
            total++;
            if (a !== x.e) begin
                bad++;
                $display("FAIL main step%0d: got addr=%h iren=%b dren=%b dwen=%b pcw=%b halt=%b cnt=%0d | want addr=%h iren=%b dren=%b dwen=%b pcw=%b halt=%b cnt=%0d",
                         x.id, a.addr, a.iren, a.dren, a.dwen, a.pcw, a.hlt, a.cnt,
                         x.e.addr, x.e.iren, x.e.dren, x.e.dwen, x.e.pcw, x.e.hlt, x.e.cnt);
            end
        end
        if (q_b.size() > 0) begin
            exp_b_t y;
            y = q_b.pop_front();
            total++;
            if (instr_cnt_b !== y.cnt) begin
                bad++;
                $display("FAIL wrap step%0d: got cnt=%0d want cnt=%0d", y.id, instr_cnt_b, y.cnt);
            end
        end
    end

    task automatic step(input logic rst, input logic ih, input logic dh,
                        input logic dr, input logic dw, input logic hl,
                        input logic [31:0] np,
                        input logic [31:0] ea, input logic ei, input logic edr,
                        input logic edw, input logic epw, input logic eh,
                        input logic [31:0] ec);
        exp_t x;
        RST = rst; ihit = ih; dhit = dh; dRENi = dr; dWENi = dw; halt = hl; npc = np;
        x.id = step_id;
        x.e  = '{addr: ea, iren: ei, dren: edr, dwen: edw, pcw: epw, hlt: eh, cnt: ec};
        q_main.push_back(x);
        step_id++;
        @(posedge CLK);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic ih, input logic [3:0] ec);
        exp_b_t y;
        rst_b = rst; ihit_b = ih;
        y.id = step_id;
        y.cnt = ec;
        q_b.push_back(y);
        step_id++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; dRENi = 1'b0; dWENi = 1'b0;
        halt = 1'b0; npc = 32'h0;
        rst_b = 1'b1; ihit_b = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        //   rst ih dh dr dw hl npc           | addr          iren dr dw pcw hlt cnt
        // Reset held with ihit: pulse must stay low
        step(1, 1, 0, 0, 0, 0, 32'h4,          32'h0,        1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h4,          32'h0,        1, 0, 0, 0, 0, 0);
        // ALU stream
        step(0, 1, 0, 0, 0, 0, 32'h4,          32'h0,        1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 32'h8,          32'h4,        1, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 32'hC,          32'h8,        1, 0, 0, 1, 0, 2);
        step(0, 0, 0, 0, 0, 0, 32'h10,         32'hC,        1, 0, 0, 0, 0, 3);
        // Load with four wait cycles; ihit during DATA is ignored
        step(0, 1, 0, 1, 0, 0, 32'h10,         32'hC,        1, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0, 0, 32'h10,         32'hC,        0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 0, 32'h10,         32'hC,        0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 0, 32'h10,         32'hC,        0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 0, 32'h10,         32'hC,        0, 1, 0, 0, 0, 3);
        step(0, 0, 1, 0, 0, 0, 32'h10,         32'hC,        0, 1, 0, 1, 0, 3);
        // dhit in FETCH is ignored
        step(0, 0, 1, 0, 0, 0, 32'h14,         32'h10,       1, 0, 0, 0, 0, 4);
        // Both enables: write wins; completion jumps to 0x20
        step(0, 1, 0, 1, 1, 0, 32'h14,         32'h10,       1, 0, 0, 0, 0, 4);
        step(0, 0, 0, 0, 0, 0, 32'h14,         32'h10,       0, 0, 1, 0, 0, 4);
        step(0, 0, 1, 0, 0, 0, 32'h20,         32'h10,       0, 0, 1, 1, 0, 4);
        // Halt at 0x20 with count 5, then frozen
        step(0, 1, 0, 0, 0, 1, 32'h24,         32'h20,       1, 0, 0, 0, 0, 5);
        for (int i = 0; i < 10; i++)
            step(0, 1, 1, 1, i[0], 0, 32'h99,  32'h20,       0, 0, 0, 0, 1, 5);
        // Reset out of HALTED
        step(1, 0, 0, 0, 0, 0, 32'h0,          32'h20,       0, 0, 0, 0, 1, 5);
        // Reset mid-store at a non-initial PC; pending dhit must not retire
        step(0, 1, 0, 0, 0, 0, 32'h40,         32'h0,        1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 32'h44,         32'h40,       1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 32'h44,         32'h40,       0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 32'h44,         32'h0,        1, 0, 0, 0, 0, 0);
        // Low PC bits pass straight through
        step(0, 1, 0, 0, 0, 0, 32'h3,          32'h0,        1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h3,          32'h3,        1, 0, 0, 0, 0, 1);

        // Four-bit counter: 17 retirements wrap to 1
        for (int k = 0; k < 17; k++)
            step_b(0, 1, 4'(k));
        step_b(0, 0, 4'd1);

        repeat (2) @(negedge CLK);
        if (q_main.size() != 0 || q_b.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_main.size() + q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
